// File: rtl/apb_mem_slave_pkg.sv
// apb_mem_slave_pkg: shared widths, depth, read latency and FSM state type for the APB SRAM completer
package apb_mem_slave_pkg;
  localparam int param_WIDTH_ADDR = 8;
  localparam int param_WIDTH_DATA = 32;
  localparam int MEM_DEPTH = 256;
  localparam int RD_LATENCY = 1;
  typedef enum logic [1:0] {IDLE, WR_ACC, RD_WAIT, RD_DONE} apb_slv_state_e;
endpackage

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB3 completer turning each transfer into one single-port synchronous SRAM access
module apb_mem_slave
  import apb_mem_slave_pkg::*;
#(
  parameter int param_WIDTH_ADDR = apb_mem_slave_pkg::param_WIDTH_ADDR,
  parameter int param_WIDTH_DATA = apb_mem_slave_pkg::param_WIDTH_DATA,
  parameter int MEM_DEPTH = apb_mem_slave_pkg::MEM_DEPTH,
  parameter int RD_LATENCY = apb_mem_slave_pkg::RD_LATENCY
) (
  input  logic                        sysclk,
  input  logic                        sysrst,
  input  logic [param_WIDTH_ADDR-1:0] PADDR,
  input  logic                        PWRITE,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic [param_WIDTH_DATA-1:0] PWDATA,
  output logic [param_WIDTH_DATA-1:0] PRDATA,
  output logic                        PREADY,
  output logic                        mem_cs,
  output logic                        mem_we,
  output logic [param_WIDTH_ADDR-1:0] mem_addr,
  output logic [param_WIDTH_DATA-1:0] mem_wdata,
  input  logic [param_WIDTH_DATA-1:0] mem_rdata
);
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
    $error("RD_LATENCY must be 1..4");
  end
  apb_slv_state_e state;
  logic [2:0] cnt;
  logic rng;
  logic in_rng;
  assign in_rng = int'(PADDR) < MEM_DEPTH;
  // Transfer FSM: setup launches the SRAM access, reads wait RD_LATENCY+1 cycles before PREADY
  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      state <= IDLE;
      PREADY <= 1'b0;
      PRDATA <= '0;
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cnt <= '0;
      rng <= 1'b0;
    end else begin
      case (state)
        IDLE: if (PSEL && !PENABLE) begin
          state <= PWRITE ? WR_ACC : RD_WAIT;
          PREADY <= PWRITE;
          mem_cs <= in_rng;
          mem_we <= PWRITE && in_rng;
          rng <= in_rng;
          cnt <= '0;
          if (in_rng) mem_addr <= PADDR;
          if (in_rng && PWRITE) mem_wdata <= PWDATA;
        end
        RD_WAIT: begin
          mem_cs <= 1'b0;
          if (!PSEL) state <= IDLE;
          else if (cnt == 3'(RD_LATENCY)) begin
            PRDATA <= rng ? mem_rdata : '0;
            PREADY <= 1'b1;
            state <= RD_DONE;
          end else cnt <= cnt + 3'd1;
        end
        default: begin
          state <= IDLE;
          PREADY <= 1'b0;
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: scoreboard bench driving APB transfers against a synchronous SRAM model
module tb_apb_mem_slave;
  import apb_mem_slave_pkg::*;
  localparam int AW = param_WIDTH_ADDR;
  localparam int DW = param_WIDTH_DATA;
  localparam int DEPTH = 200;
  localparam int LAT = 1;
  logic sysclk = 1'b0;
  logic sysrst = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic PWRITE = 1'b0;
  logic PSEL = 1'b0;
  logic PENABLE = 1'b0;
  logic [DW-1:0] PWDATA = '0;
  logic [DW-1:0] PRDATA;
  logic PREADY;
  logic mem_cs;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  int checks = 0;
  int errors = 0;
  int cs_any = 0;
  int cs_wr = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] sram [0:255];
  logic [DW-1:0] pipe [LAT];

  always #5 sysclk = ~sysclk;

  apb_mem_slave #(
    .param_WIDTH_ADDR(AW),
    .param_WIDTH_DATA(DW),
    .MEM_DEPTH(DEPTH),
    .RD_LATENCY(LAT)
  ) dut (
    .sysclk(sysclk),
    .sysrst(sysrst),
    .PADDR(PADDR),
    .PWRITE(PWRITE),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .mem_cs(mem_cs),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge sysclk) begin
    if (mem_cs && mem_we) sram[mem_addr] <= mem_wdata;
    pipe[0] <= sram[mem_addr];
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge sysclk) begin
    if (mem_cs) cs_any++;
    if (mem_cs && mem_we) cs_wr++;
    if (PSEL && PENABLE && PREADY && !PWRITE) begin
      chk("sb_nonempty", DW'(exp_q.size() > 0), DW'(1));
      if (exp_q.size() > 0) chk("prdata", PRDATA, exp_q.pop_front());
    end
  end

  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int ws);
    int waits = 0;
    @(posedge sysclk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    if (!w) exp_q.push_back(int'(a) < DEPTH ? ref_mem[a] : DW'(0));
    else if (int'(a) < DEPTH) ref_mem[a] = d;
    @(posedge sysclk); #1;
    PENABLE = 1'b1;
    while (!PREADY && waits < 20) begin
      @(posedge sysclk); #1;
      waits++;
    end
    chk(w ? "wr_waits" : "rd_waits", DW'(waits), DW'(ws));
  endtask

  task automatic idle(input int n);
    @(posedge sysclk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (n) @(posedge sysclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0;
    logic rdy;
    #1 sysrst = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    chk("rst_pready", DW'(PREADY), '0);
    chk("rst_prdata", PRDATA, '0);
    chk("rst_cs", DW'(mem_cs), '0);
    chk("rst_we", DW'(mem_we), '0);
    chk("rst_addr", DW'(mem_addr), '0);
    chk("rst_wdata", mem_wdata, '0);
    sysrst = 1'b0;
    xfer(1'b1, 8'h10, 32'hDEADBEEF, 0);
    idle(1);
    chk("hold_addr", DW'(mem_addr), DW'(8'h10));
    chk("hold_wdata", mem_wdata, 32'hDEADBEEF);
    xfer(1'b0, 8'h10, '0, LAT + 1);
    idle(1);
    chk("prdata_hold", PRDATA, 32'hDEADBEEF);
    c0 = cs_wr;
    for (int i = 0; i < 4; i++) xfer(1'b1, AW'(i), DW'(i + 1), 0);
    for (int i = 0; i < 4; i++) xfer(1'b0, AW'(i), '0, LAT + 1);
    idle(1);
    chk("wr_pulses", DW'(cs_wr - c0), DW'(4));
    c0 = cs_any;
    xfer(1'b1, 8'hFF, 32'h55AA55AA, 0);
    xfer(1'b0, 8'hFF, '0, LAT + 1);
    idle(1);
    chk("oor_cs", DW'(cs_any - c0), '0);
    xfer(1'b0, 8'h10, '0, LAT + 1);
    xfer(1'b1, 8'h10, 32'hCAFEF00D, 0);
    idle(1);
    @(posedge sysclk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h10;
    @(posedge sysclk); #1;
    PSEL = 1'b0;
    rdy = 1'b0;
    repeat (6) begin
      @(negedge sysclk);
      rdy = rdy | PREADY;
    end
    chk("abort_pready", DW'(rdy), '0);
    chk("abort_prdata", PRDATA, 32'hDEADBEEF);
    xfer(1'b0, 8'h10, '0, LAT + 1);
    idle(1);
    @(posedge sysclk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h01;
    @(posedge sysclk); #1;
    PENABLE = 1'b1;
    #2 sysrst = 1'b1;
    #1;
    chk("mrst_pready", DW'(PREADY), '0);
    chk("mrst_prdata", PRDATA, '0);
    chk("mrst_cs", DW'(mem_cs), '0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge sysclk); #1;
    sysrst = 1'b0;
    xfer(1'b0, 8'h10, '0, LAT + 1);
    idle(1);
    c0 = cs_any;
    rdy = 1'b0;
    @(posedge sysclk); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h20; PWDATA = 32'h12345678;
    repeat (4) begin
      @(negedge sysclk);
      rdy = rdy | PREADY;
    end
    chk("nosetup_cs", DW'(cs_any - c0), '0);
    chk("nosetup_pready", DW'(rdy), '0);
    idle(2);
    chk("sb_empty", DW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
